// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between a FIFO pointer controller and its user.
// The master drives requests and flushes; the slave returns pointers, enables and status.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              WR_EN;
    logic              RD_EN;
    logic              CLR;
    logic              ERR_CLR;
    logic [ADDR_W:0]   WR_PTR;
    logic [ADDR_W:0]   RD_PTR;
    logic              WE;
    logic              RE;
    logic              Full;
    logic              Empty;
    logic              Almost_Full;
    logic              Almost_Empty;
    logic [ADDR_W:0]   COUNT;
    logic              OVF;
    logic              UDF;
    logic [ADDR_W:0]   HWM;

    modport master (
        output WR_EN, RD_EN, CLR, ERR_CLR,
        input  WR_PTR, RD_PTR, WE, RE, Full, Empty, Almost_Full, Almost_Empty,
               COUNT, OVF, UDF, HWM
    );

    modport slave (
        input  WR_EN, RD_EN, CLR, ERR_CLR,
        output WR_PTR, RD_PTR, WE, RE, Full, Empty, Almost_Full, Almost_Empty,
               COUNT, OVF, UDF, HWM
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/status controller: wrap-bit pointers, full/empty and almost flags,
// occupancy, sticky overflow/underflow and a high-water mark for a dual-port RAM.
module fifo_ptr_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned AF_THRESH = (2**ADDR_W) - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    if (!(ADDR_W >= 2 && AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < DEPTH)) begin : g_param_check
        $error("fifo_ptr_ctrl: illegal ADDR_W/AE_THRESH/AF_THRESH combination");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [PW-1:0] hwm;
    logic          ovf;
    logic          udf;
    logic          full;
    logic          empty;
    logic          we;
    logic          re;

    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        // RST gating keeps WE low while reset is held even if WR_EN is asserted
        we    = bus.WR_EN & ~full  & ~bus.CLR & RST;
        re    = bus.RD_EN & ~empty & ~bus.CLR & RST;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{ADDR_W{1'b0}}, we};
            rd_ptr <= rd_ptr + {{ADDR_W{1'b0}}, re};
        end
    end

    // A coincident set condition overrides ERR_CLR for the sticky flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf <= 1'b0;
            udf <= 1'b0;
            hwm <= '0;
        end else begin
            ovf <= (ovf & ~bus.ERR_CLR) | (bus.WR_EN & full);
            udf <= (udf & ~bus.ERR_CLR) | (bus.RD_EN & empty);
            if (bus.ERR_CLR) begin
                hwm <= '0;
            end else if (count > hwm) begin
                hwm <= count;
            end
        end
    end

    assign bus.WR_PTR       = wr_ptr;
    assign bus.RD_PTR       = rd_ptr;
    assign bus.WE           = we;
    assign bus.RE           = re;
    assign bus.Full         = full;
    assign bus.Empty        = empty;
    assign bus.Almost_Full  = (count >= AF_T);
    assign bus.Almost_Empty = (count <= AE_T);
    assign bus.COUNT        = count;
    assign bus.OVF          = ovf;
    assign bus.UDF          = udf;
    assign bus.HWM          = hwm;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl at ADDR_W=4 (DEPTH 16, AF 12, AE 2).
module tb_fifo_ptr_ctrl;
    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    fifo_ptr_ctrl_if #(.ADDR_W(4)) bus ();

    fifo_ptr_ctrl #(
        .ADDR_W    (4),
        .AF_THRESH (12),
        .AE_THRESH (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST         = 1'b0;
        bus.WR_EN   = 1'b1;
        bus.RD_EN   = 1'b1;
        bus.CLR     = 1'b0;
        bus.ERR_CLR = 1'b0;

        // Reset state, with requests asserted during reset
        #12;
        chk("rst_count", 32'(bus.COUNT), 0);
        chk("rst_empty", 32'(bus.Empty), 1);
        chk("rst_ae",    32'(bus.Almost_Empty), 1);
        chk("rst_full",  32'(bus.Full), 0);
        chk("rst_af",    32'(bus.Almost_Full), 0);
        chk("rst_we",    32'(bus.WE), 0);
        chk("rst_re",    32'(bus.RE), 0);
        chk("rst_ovf",   32'(bus.OVF), 0);
        chk("rst_udf",   32'(bus.UDF), 0);
        chk("rst_hwm",   32'(bus.HWM), 0);
        chk("rst_wrptr", 32'(bus.WR_PTR), 0);
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        RST = 1'b1;
        tick();

        // 1: sixteen writes to Full, then a blocked 17th
        bus.WR_EN = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            #1;
            chk("t1_we", 32'(bus.WE), 1);
            tick();
            chk("t1_count", 32'(bus.COUNT), i);
            chk("t1_ae",    32'(bus.Almost_Empty), (i <= 2) ? 1 : 0);
            chk("t1_af",    32'(bus.Almost_Full), (i >= 12) ? 1 : 0);
            chk("t1_full",  32'(bus.Full), (i == 16) ? 1 : 0);
        end
        chk("t1_hwm_lag", 32'(bus.HWM), 15);
        chk("t1_ovf_pre", 32'(bus.OVF), 0);
        #1;
        chk("t1_we17", 32'(bus.WE), 0);
        tick();
        chk("t1_ovf",   32'(bus.OVF), 1);
        chk("t1_count17", 32'(bus.COUNT), 16);
        chk("t1_wrptr", 32'(bus.WR_PTR), 32'b10000);
        chk("t1_hwm",   32'(bus.HWM), 16);

        // 2: drain to Empty, then a blocked extra read
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            #1;
            chk("t2_re", 32'(bus.RE), 1);
            tick();
            chk("t2_count", 32'(bus.COUNT), 16 - i);
            chk("t2_empty", 32'(bus.Empty), (i == 16) ? 1 : 0);
        end
        chk("t2_udf_pre", 32'(bus.UDF), 0);
        #1;
        chk("t2_re17", 32'(bus.RE), 0);
        tick();
        chk("t2_udf",   32'(bus.UDF), 1);
        chk("t2_ovf",   32'(bus.OVF), 1);
        chk("t2_rdptr", 32'(bus.RD_PTR), 32'b10000);
        chk("t2_empty17", 32'(bus.Empty), 1);

        // Clear sticky state before the wrap run
        bus.RD_EN   = 1'b0;
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        chk("clr_ovf", 32'(bus.OVF), 0);
        chk("clr_udf", 32'(bus.UDF), 0);
        chk("clr_hwm", 32'(bus.HWM), 0);

        // 3: COUNT=5, then 40 simultaneous cycles; pointers wrap 31->0
        bus.WR_EN = 1'b1;
        repeat (5) tick();
        chk("t3_count5", 32'(bus.COUNT), 5);
        bus.RD_EN = 1'b1;
        for (int unsigned i = 0; i < 40; i++) begin
            tick();
            chk("t3_count", 32'(bus.COUNT), 5);
        end
        chk("t3_wrptr", 32'(bus.WR_PTR), 29);
        chk("t3_rdptr", 32'(bus.RD_PTR), 24);
        chk("t3_ovf",   32'(bus.OVF), 0);
        chk("t3_udf",   32'(bus.UDF), 0);
        chk("t3_full",  32'(bus.Full), 0);
        chk("t3_empty", 32'(bus.Empty), 0);
        chk("t3_hwm",   32'(bus.HWM), 5);

        // 4: simultaneous requests at Full and at Empty
        bus.RD_EN = 1'b0;
        repeat (11) tick();
        chk("t4_full", 32'(bus.Full), 1);
        bus.RD_EN = 1'b1;
        #1;
        chk("t4_we_full", 32'(bus.WE), 0);
        chk("t4_re_full", 32'(bus.RE), 1);
        tick();
        chk("t4_count15", 32'(bus.COUNT), 15);
        chk("t4_ovf",     32'(bus.OVF), 1);
        bus.WR_EN = 1'b0;
        repeat (15) tick();
        chk("t4_empty", 32'(bus.Empty), 1);
        chk("t4_rdptr", 32'(bus.RD_PTR), 8);
        bus.WR_EN = 1'b1;
        #1;
        chk("t4_we_empty", 32'(bus.WE), 1);
        chk("t4_re_empty", 32'(bus.RE), 0);
        tick();
        chk("t4_count1", 32'(bus.COUNT), 1);
        chk("t4_hwm",    32'(bus.HWM), 16);

        // 5: CLR at COUNT=9 with WR_EN, then ERR_CLR colliding with an underflow
        bus.RD_EN = 1'b0;
        repeat (8) tick();
        chk("t5_count9", 32'(bus.COUNT), 9);
        bus.CLR = 1'b1;
        #1;
        chk("t5_we_clr", 32'(bus.WE), 0);
        tick();
        bus.CLR   = 1'b0;
        bus.WR_EN = 1'b0;
        chk("t5_count", 32'(bus.COUNT), 0);
        chk("t5_empty", 32'(bus.Empty), 1);
        chk("t5_wrptr", 32'(bus.WR_PTR), 0);
        chk("t5_hwm",   32'(bus.HWM), 16);
        bus.RD_EN   = 1'b1;
        bus.ERR_CLR = 1'b1;
        tick();
        bus.RD_EN   = 1'b0;
        bus.ERR_CLR = 1'b0;
        chk("t5_udf",     32'(bus.UDF), 1);
        chk("t5_ovf",     32'(bus.OVF), 0);
        chk("t5_hwm_clr", 32'(bus.HWM), 0);

        // 6: asynchronous reset between edges during a write burst
        bus.WR_EN = 1'b1;
        repeat (3) tick();
        chk("t6_count3", 32'(bus.COUNT), 3);
        #2;
        RST = 1'b0;
        #1;
        chk("t6_count", 32'(bus.COUNT), 0);
        chk("t6_wrptr", 32'(bus.WR_PTR), 0);
        chk("t6_rdptr", 32'(bus.RD_PTR), 0);
        chk("t6_udf",   32'(bus.UDF), 0);
        chk("t6_ovf",   32'(bus.OVF), 0);
        chk("t6_hwm",   32'(bus.HWM), 0);
        chk("t6_we",    32'(bus.WE), 0);
        tick();
        chk("t6_hold",  32'(bus.WR_PTR), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
